// File: rtl/apb_pkg.sv
// Shared encodings and default widths for the APB requester bridge.
package apb_pkg;

  localparam int unsigned DATA_SIZE = 8;
  localparam int unsigned ADDR_SIZE = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b01,
    ST_SETUP  = 2'b10,
    ST_ACCESS = 2'b11
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response port plus APB bus signals of the bridge, with bridge and environment views.
interface apb_master_bridge_if #(
  parameter int unsigned data_size    = apb_pkg::DATA_SIZE,
  parameter int unsigned address_size = apb_pkg::ADDR_SIZE
);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [address_size-1:0] req_addr;
  logic [data_size-1:0]    req_wdata;

  logic                    rsp_valid;
  logic                    rsp_err;
  logic [data_size-1:0]    rsp_rdata;

  logic                    pselx;
  logic                    penable;
  logic                    pwrite;
  logic [address_size-1:0] paddr;
  logic [data_size-1:0]    pwdata;
  logic                    pready;
  logic [data_size-1:0]    prdata;

  // Bridge side: consumes requests, drives the APB bus.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, pready, prdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output pselx, penable, pwrite, paddr, pwdata
  );

  // Environment side: requester plus APB slave.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, pready, prdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  pselx, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: runs SETUP/ACCESS per accepted command and
// returns a one-cycle response, aborting when the slave stalls too long.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned data_size    = DATA_SIZE,
  parameter int unsigned address_size = ADDR_SIZE,
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned TO_WIDTH     = 5
) (
  input logic               clock,
  input logic               resetn,
  apb_master_bridge_if.master bus
);

  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_WIDTH-1:0] CNT_MAX = {TO_WIDTH{1'b1}};
  localparam logic [TO_WIDTH-1:0] CNT_LIM = TO_WIDTH'(TIMEOUT);

  apb_state_e                state_q, state_d;
  logic                      req_ready_q, req_ready_d;
  logic                      pselx_q, pselx_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [address_size-1:0]   paddr_q, paddr_d;
  logic [data_size-1:0]      pwdata_q, pwdata_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [data_size-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic [TO_WIDTH-1:0]       wait_cnt_q, wait_cnt_d;
  logic [TO_WIDTH-1:0]       wait_cnt_inc;

  // Wait counter saturates instead of wrapping when no timeout is configured.
  assign wait_cnt_inc = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + TO_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    pselx_d     = pselx_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    wait_cnt_d  = wait_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid) begin
          state_d     = ST_SETUP;
          req_ready_d = 1'b0;
          pselx_d     = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = bus.req_write;
          paddr_d     = bus.req_addr;
          pwdata_d    = bus.req_wdata;
        end
      end
      ST_SETUP: begin
        state_d    = ST_ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end
      ST_ACCESS: begin
        if (bus.pready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          pselx_d     = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          if (TO_EN && (wait_cnt_inc == CNT_LIM)) begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
            pselx_d     = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        pselx_d     = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      pselx_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.pselx     = pselx_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench: stimulus pushes expected responses, a monitor checks the bus and responses.
module tb_apb_master_bridge;

  localparam int unsigned DW       = 8;
  localparam int unsigned AW       = 5;
  localparam int unsigned TIMEOUT  = 16;
  localparam int unsigned TO_WIDTH = 5;

  typedef struct {
    bit          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit          err;
    logic [DW-1:0] rdata;
    int          psel_cycles;
  } exp_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  apb_master_bridge_if #(.data_size(DW), .address_size(AW)) bus ();

  apb_master_bridge #(
    .data_size(DW), .address_size(AW), .TIMEOUT(TIMEOUT), .TO_WIDTH(TO_WIDTH)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  exp_t          exp_q[$];
  int            wait_q[$];
  logic [DW-1:0] ref_mem[32];
  logic [DW-1:0] slv_mem[32];
  int            checks = 0;
  int            failures = 0;
  int            psel_cnt = 0;
  int            since_setup = 100;
  bit            mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: memory semantics and timing derived from the transfer rules.
  task automatic issue(input bit write, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int waits);
    exp_t e;
    int   n = 0;
    bit   to = (waits < 0) || (waits >= int'(TIMEOUT));
    e.write = write; e.addr = addr; e.wdata = wdata; e.err = to;
    e.psel_cycles = to ? 1 + int'(TIMEOUT) : 2 + waits;
    e.rdata = (to || write) ? '0 : ref_mem[addr];
    if (!to && write) ref_mem[addr] = wdata;
    bus.req_valid = 1'b1; bus.req_write = write; bus.req_addr = addr; bus.req_wdata = wdata;
    while (!bus.req_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 32'(n), 32'd0);
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clock);
      exp_q.push_back(e);
      wait_q.push_back(waits < 0 ? 1000000 : waits);
      @(negedge clock);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // APB slave: per-transfer wait states from wait_q, random pready/prdata outside ACCESS.
  initial begin
    int cur_wait = 0;
    bit in_access = 1'b0;
    bus.pready = 1'b0;
    bus.prdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (bus.pselx && !bus.penable) begin
        cur_wait  = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        in_access = 1'b0;
        bus.pready = 1'($urandom);
        bus.prdata = DW'($urandom);
      end else if (bus.pselx && bus.penable) begin
        if (in_access) cur_wait--;
        in_access  = 1'b1;
        bus.pready = (cur_wait == 0);
        bus.prdata = bus.pwrite ? DW'($urandom) : slv_mem[bus.paddr];
        if (cur_wait == 0 && bus.pwrite) slv_mem[bus.paddr] = bus.pwdata;
      end else begin
        in_access  = 1'b0;
        bus.pready = 1'($urandom);
        bus.prdata = DW'($urandom);
      end
    end
  end

  // Monitor: bus contents against the pending command, responses against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (resetn && mon_en) begin
        if (bus.pselx) begin
          psel_cnt++;
          if (!bus.penable) begin
            check("setup_spacing_ok", 32'(since_setup >= 3), 32'd1);
            since_setup = 0;
          end
          if (exp_q.size() == 0) begin
            check("psel_without_cmd", 32'(bus.pselx), 32'd0);
          end else begin
            e = exp_q[0];
            check("paddr", 32'(bus.paddr), 32'(e.addr));
            check("pwrite", 32'(bus.pwrite), 32'(e.write));
            check("pwdata", 32'(bus.pwdata), 32'(e.wdata));
          end
        end
        if (bus.rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
            check("psel_cycles", 32'(psel_cnt), 32'(e.psel_cycles));
            check("psel_low_at_rsp", 32'(bus.pselx), 32'd0);
          end
          psel_cnt = 0;
        end
        check("req_ready", 32'(bus.req_ready), 32'(exp_q.size() == 0));
        since_setup++;
      end
    end
  end

  initial begin
    int n;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = DW'($urandom);
      slv_mem[i] = ref_mem[i];
    end
    repeat (3) @(negedge clock);
    check("rst_pselx", 32'(bus.pselx), 32'd0);
    check("rst_penable", 32'(bus.penable), 32'd0);
    check("rst_pwrite", 32'(bus.pwrite), 32'd0);
    check("rst_paddr", 32'(bus.paddr), 32'd0);
    check("rst_pwdata", 32'(bus.pwdata), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    resetn = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);

    issue(1'b1, 5'h03, 8'hA5, 2);
    issue(1'b0, 5'h03, 8'h00, 1);
    issue(1'b1, 5'h1F, 8'h3C, 0);
    issue(1'b0, 5'h1F, 8'h5A, 0);
    issue(1'b0, 5'h05, 8'h00, -1);
    issue(1'b1, 5'h04, 8'h55, 3);
    issue(1'b1, 5'h07, 8'h11, 0);
    issue(1'b0, 5'h07, 8'h00, 15);
    issue(1'b1, 5'h08, 8'h99, 16);
    issue(1'b0, 5'h08, 8'h00, 0);
    drain();

    // Reset in the middle of a stalled ACCESS phase.
    issue(1'b0, 5'h0A, 8'h00, -1);
    n = 0;
    while (!(bus.pselx && bus.penable) && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("reached_access", 32'(bus.pselx && bus.penable), 32'd1);
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    exp_q.delete();
    wait_q.delete();
    @(posedge clock);
    #1;
    check("midrst_pselx", 32'(bus.pselx), 32'd0);
    check("midrst_penable", 32'(bus.penable), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    psel_cnt = 0;
    since_setup = 100;
    @(negedge clock);
    resetn = 1'b1;
    repeat (4) @(negedge clock);

    for (int k = 0; k < 250; k++) begin
      int r = int'($urandom_range(0, 19));
      int waits = (r == 0) ? -1 : (r == 1) ? 15 : (r == 2) ? 16 : int'($urandom_range(0, 4));
      issue(1'($urandom), AW'($urandom), DW'($urandom), waits);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    drain();
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
